// File: rtl/ram_word_arbiter_pkg.sv
// Shared constants for the two-port word arbiter: FSM encodings, port ids, half selects.
// Used by ram_word_arbiter and ram_arb_select (both honour RAM_ARB_RR_EN).
package ram_word_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_LO   = 2'd1;
  localparam arb_state_t ST_HI   = 2'd2;
  localparam arb_state_t ST_DONE = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/ram_arb_select.sv
// Eligibility masking and grant decision for the two requesters.
// RAM_ARB_RR_EN selects round-robin tie-break; otherwise A always wins a tie.
module ram_arb_select
  import ram_word_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic a_ack,
  input  logic b_req,
  input  logic b_ack,
`ifdef RAM_ARB_RR_EN
  input  logic last_grant,
  output logic tie,
`endif
  output logic grant,
  output logic grant_port
);

  logic a_elig;
  logic b_elig;

  // A port whose ack is high this cycle is still holding the old request.
  assign a_elig = a_req & ~a_ack;
  assign b_elig = b_req & ~b_ack;
  assign grant  = a_elig | b_elig;

`ifdef RAM_ARB_RR_EN
  assign tie = a_elig & b_elig;
`endif

  always_comb begin
    grant_port = PORT_A;
    if (a_elig && b_elig) begin
`ifdef RAM_ARB_RR_EN
      grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
`else
      grant_port = PORT_A;
`endif
    end else if (b_elig) begin
      grant_port = PORT_B;
    end
  end

endmodule

// File: rtl/ram_word_arbiter.sv
// Two-port 32-bit word arbiter serialising each access into two 16-bit RAM cycles.
// Define RAM_ARB_RR_EN for round-robin tie-break; default build is fixed priority to A.
module ram_word_arbiter
  import ram_word_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-2:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-2:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic              ram_write,
  input  logic [15:0]       ram_rdata
);

  // state | meaning
  // IDLE  | waiting for an eligible request
  // LO    | low halfword on the RAM bus
  // HI    | high halfword on the RAM bus, low read data captured
  // DONE  | high read data arrives, result and ack registered
  arb_state_t        state;
  logic              sel_port;
  logic              we_q;
  logic [ADDR_W-2:0] addr_q;
  logic [15:0]       wdata_hi_q;
  logic [15:0]       lo_q;

  logic              grant;
  logic              grant_port;
  logic              g_we;
  logic [ADDR_W-2:0] g_addr;
  logic [31:0]       g_wdata;

`ifdef RAM_ARB_RR_EN
  logic last_grant;
  logic tie;
`endif

  ram_arb_select u_select (
    .a_req      (a_req),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_ack      (b_ack),
`ifdef RAM_ARB_RR_EN
    .last_grant (last_grant),
    .tie        (tie),
`endif
    .grant      (grant),
    .grant_port (grant_port)
  );

  always_comb begin
    g_we    = a_we;
    g_addr  = a_addr;
    g_wdata = a_wdata;
    if (grant_port == PORT_B) begin
      g_we    = b_we;
      g_addr  = b_addr;
      g_wdata = b_wdata;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Remembers only contested wins, so back-to-back ties alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_B;
    end else if (state == ST_IDLE && tie) begin
      last_grant <= grant_port;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_port   <= PORT_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      ram_raddr  <= '0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      ram_write  <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            sel_port   <= grant_port;
            we_q       <= g_we;
            addr_q     <= g_addr;
            wdata_hi_q <= g_wdata[31:16];
            // RAM bus is registered, so the low half is launched on accept.
            ram_raddr  <= {g_addr, HALF_LO};
            ram_waddr  <= {g_addr, HALF_LO};
            ram_wdata  <= g_wdata[15:0];
            ram_write  <= g_we;
            state      <= ST_LO;
          end
        end
        ST_LO: begin
          ram_raddr <= {addr_q, HALF_HI};
          ram_waddr <= {addr_q, HALF_HI};
          ram_wdata <= wdata_hi_q;
          ram_write <= we_q;
          state     <= ST_HI;
        end
        ST_HI: begin
          lo_q      <= ram_rdata;
          ram_write <= 1'b0;
          state     <= ST_DONE;
        end
        default: begin
          if (sel_port == PORT_A) begin
            a_ack <= 1'b1;
            if (!we_q) a_rdata <= {ram_rdata, lo_q};
          end else begin
            b_ack <= 1'b1;
            if (!we_q) b_rdata <= {ram_rdata, lo_q};
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
